// File: rtl/uart_pack.sv
// uart_pack: shared UART data width and receiver FSM state type
package uart_pack;
  localparam int uart_width = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous single-bit input
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic r_meta;
  always_ff @(posedge clk_i)
    if (!rst_i) {q_o, r_meta} <= {2{RST_VAL}};
    else {q_o, r_meta} <= {r_meta, d_i};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with framing-error detection
module uart_rx
  import uart_pack::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_i,
  input  logic                  rx_i,
  output logic [uart_width-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(uart_width + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(uart_width - 1);
  rx_state_t             r_state, w_state;
  logic [TW-1:0]         r_tick, w_tick;
  logic [BW-1:0]         r_bit, w_bit;
  logic [uart_width-1:0] r_shift, w_shift, w_data;
  logic                  w_rx_s, w_valid, w_ferr;
  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (rx_i),
    .q_o  (w_rx_s)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tick      <= w_tick;
      r_bit       <= w_bit;
      r_shift     <= w_shift;
      data_o      <= w_data;
      valid_o     <= w_valid;
      frame_err_o <= w_ferr;
    end
  end
  always_comb begin
    w_state = r_state;
    w_tick  = tick_i ? r_tick + TW'(1) : r_tick;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_data  = data_o;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      IDLE: if (tick_i && !w_rx_s) begin
        w_state = START;
        w_tick  = '0;
      end
      START: if (tick_i && r_tick == HALF) begin
        w_state = w_rx_s ? IDLE : DATA;
        w_tick  = '0;
        w_bit   = '0;
      end
      DATA: if (tick_i && r_tick == LAST) begin
        w_shift = {w_rx_s, r_shift[uart_width-1:1]};
        w_bit   = r_bit + BW'(1);
        w_tick  = '0;
        w_state = (r_bit == LAST_BIT) ? STOP : DATA;
      end
      STOP: if (tick_i && r_tick == LAST) begin
        w_state = w_rx_s ? IDLE : WAIT_HIGH;
        w_valid = w_rx_s;
        w_ferr  = !w_rx_s;
        w_data  = w_rx_s ? r_shift : data_o;
      end
      // a low line here is a break or lost framing, so no start is accepted
      WAIT_HIGH: if (tick_i && w_rx_s) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  assign busy_o = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench with a frame-level reference model
module tb_uart_rx;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       tick_i = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, busy_o;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tick_i     (tick_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         good;
    logic [7:0] d;
    int         ts;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur;
  int         checks = 0, errors = 0;
  int         cyc = 0, tdiv = 4, tcnt = 0;
  int         n_valid = 0, n_ferr = 0;
  int         lo, hi, exp_valid, exp_ferr;
  logic [7:0] last_good = 8'h00;
  logic [7:0] rb;
  logic [7:0] fixed[4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk_i);
    tick_i = (tcnt == 0);
    tcnt = (tcnt + 1 >= tdiv) ? 0 : tcnt + 1;
  end

  // Every cycle: events must match the queue of frames sent, in order and on time,
  // and data_o must always hold the last well-framed byte.
  always @(posedge clk_i) begin
    #1;
    chk("exclusive", {31'b0, valid_o & frame_err_o}, 0);
    if (valid_o || frame_err_o) begin
      n_valid += int'(valid_o);
      n_ferr  += int'(frame_err_o);
      if (exp_q.size() == 0) chk("unexpected_event", {30'b0, valid_o, frame_err_o}, 0);
      else begin
        cur = exp_q.pop_front();
        chk("event_kind", {31'b0, valid_o}, {31'b0, cur.good});
        if (cur.good) last_good = cur.d;
        lo = cur.ts + 152 * tdiv;
        hi = cur.ts + 153 * tdiv + 3;
        checks++;
        if (cyc < lo || cyc > hi) begin
          errors++;
          $display("FAIL event_time: cycle %0d expected %0d..%0d", cyc, lo, hi);
        end
      end
    end
    chk("data_o", data_o, last_good);
  end

  initial begin
    repeat (99000) @(posedge clk_i);
    $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send(input logic [7:0] d, input bit stop);
    int  b = 16 * tdiv;
    ev_t e;
    e.good = stop;
    e.d    = d;
    e.ts   = cyc;
    exp_q.push_back(e);
    rx_i = 1'b0;
    repeat (b) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (b) @(negedge clk_i);
    end
    rx_i = stop;
    repeat (b) @(negedge clk_i);
  endtask

  initial begin
    repeat (4) @(negedge clk_i);
    chk("rst_data", data_o, 0);
    chk("rst_valid", {31'b0, valid_o}, 0);
    chk("rst_ferr", {31'b0, frame_err_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    rst_i = 1'b1;
    idle(128);

    send(8'hA5, 1'b1);
    idle(64);
    chk("t1_data", data_o, 8'hA5);
    chk("t1_nvalid", n_valid, 1);
    chk("t1_nferr", n_ferr, 0);
    chk("t1_busy", {31'b0, busy_o}, 0);

    rx_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("t2_busy_start", {31'b0, busy_o}, 1);
    idle(80);
    chk("t2_busy_idle", {31'b0, busy_o}, 0);
    chk("t2_nvalid", n_valid, 1);
    chk("t2_nferr", n_ferr, 0);

    send(8'h3C, 1'b0);
    repeat (160) @(negedge clk_i);
    chk("t3_nferr", n_ferr, 1);
    chk("t3_data_hold", data_o, 8'hA5);
    chk("t3_busy_wait", {31'b0, busy_o}, 1);
    idle(64);
    send(8'h81, 1'b1);
    idle(64);
    chk("t3_data", data_o, 8'h81);
    chk("t3_nvalid", n_valid, 2);

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    idle(64);
    chk("t4_nvalid", n_valid, 4);
    chk("t4_data", data_o, 8'hFF);

    rx_i = 1'b0;
    repeat (64) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      rx_i = ~i[0];
      repeat (64) @(negedge clk_i);
    end
    rx_i = 1'b1;
    repeat (32) @(negedge clk_i);
    chk("t5_busy_mid", {31'b0, busy_o}, 1);
    rst_i = 1'b0;
    last_good = 8'h00;
    @(posedge clk_i);
    #2;
    chk("t5_rst_data", data_o, 0);
    chk("t5_rst_valid", {31'b0, valid_o}, 0);
    chk("t5_rst_ferr", {31'b0, frame_err_o}, 0);
    chk("t5_rst_busy", {31'b0, busy_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    idle(128);
    chk("t5_nvalid_abort", n_valid, 4);
    send(8'h5A, 1'b1);
    idle(64);
    chk("t5_data", data_o, 8'h5A);
    chk("t5_nvalid", n_valid, 5);

    exp_valid = n_valid + 104;
    exp_ferr  = n_ferr;
    for (int i = 0; i < 104; i++) begin
      rb = (i < 4) ? fixed[i] : 8'($urandom_range(0, 255));
      send(rb, 1'b1);
      idle($urandom_range(0, 20));
    end
    idle(64);
    chk("t6_nvalid", n_valid, exp_valid);
    chk("t6_nferr", n_ferr, exp_ferr);

    tdiv = 1;
    idle(32);
    exp_valid = n_valid;
    exp_ferr  = n_ferr;
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        send(rb, 1'b0);
        exp_ferr++;
        idle(16);
      end else begin
        send(rb, 1'b1);
        exp_valid++;
      end
      idle($urandom_range(0, 8));
    end
    idle(32);
    chk("t7_nvalid", n_valid, exp_valid);
    chk("t7_nferr", n_ferr, exp_ferr);
    chk("missing_events", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
